bram_dump: RTL and testbench

- Read-back counterpart to the BRAM write/load path: after a program runs, it walks a window of data BRAM through the BRAM debug read port.
- Each 32-bit word is serialised into a byte stream with a valid/ready handshake, little-endian, so a UART TX or host link can carry results off-chip.
- Sits beside D_MEM and connects only to its debug_addr/debug_data pins. It never touches the CPU-side ports.

---
 rtl/bram_dump_if.sv | 15 +
 rtl/bram_dump.sv | 162 ++++++++++++++++
 tb/tb_bram_dump.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_dump_if.sv
// bram_dump_if: byte stream carried from bram_dump to a UART TX or host link.
//   tdata  : stream byte, little-endian order within each 32-bit word
//   tvalid : byte valid
//   tready : downstream ready
//   tlast  : final byte of a dump
// Modports: master (bram_dump side), slave (consumer side).
interface bram_dump_if;
   logic [7:0] tdata;
   logic       tvalid;
   logic       tready;
   logic       tlast;

   modport master (output tdata, output tvalid, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/bram_dump.sv
// bram_dump: walks a window of data BRAM through its debug read port and
// serialises each 32-bit word into a little-endian byte stream.
//   clk, rst        : clock (rising edge), async active-low reset
//   start           : dump request, honoured only when idle
//   base_addr       : byte address of the first word ([1:0] ignored)
//   word_cnt        : number of words to dump (0 -> immediate done)
//   busy, done      : dump in progress / one-cycle completion pulse
//   debug_addr      : address to the BRAM debug port
//   debug_data      : BRAM debug read data
//   m               : byte stream (master side)
module bram_dump #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned CNT_WIDTH  = 9
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [CNT_WIDTH-1:0]  word_cnt,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] debug_addr,
   input  logic [DATA_WIDTH-1:0] debug_data,
   bram_dump_if.master           m
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_CAPTURE,
      S_SEND,
      S_FIN
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [CNT_WIDTH-1:0]  remaining_q, remaining_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [1:0]            byte_idx_q, byte_idx_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  tvalid_q, tvalid_d;
   logic                  tlast_q, tlast_d;
   logic [7:0]            tdata_q, tdata_d;
   logic [ADDR_WIDTH-1:0] debug_addr_q, debug_addr_d;
   logic [1:0]            nxt_idx;

   assign busy       = busy_q;
   assign done       = done_q;
   assign debug_addr = debug_addr_q;
   assign m.tdata    = tdata_q;
   assign m.tvalid   = tvalid_q;
   assign m.tlast    = tlast_q;

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      remaining_d  = remaining_q;
      word_d       = word_q;
      byte_idx_d   = byte_idx_q;
      busy_d       = busy_q;
      done_d       = done_q;
      tvalid_d     = tvalid_q;
      tlast_d      = tlast_q;
      tdata_d      = tdata_q;
      debug_addr_d = debug_addr_q;
      nxt_idx      = byte_idx_q + 2'd1;

      unique case (state_q)
         S_IDLE: begin
            done_d = 1'b0;
            if (start) begin
               addr_d       = {base_addr[ADDR_WIDTH-1:2], 2'b00};
               debug_addr_d = {base_addr[ADDR_WIDTH-1:2], 2'b00};
               remaining_d  = word_cnt;
               if (word_cnt == '0) begin
                  state_d = S_FIN;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_READ;
                  busy_d  = 1'b1;
               end
            end
         end
         S_READ: begin
            state_d = S_CAPTURE;
         end
         S_CAPTURE: begin
            // Outputs are registered, so the first byte comes straight from
            // the read port rather than from word_q, which loads on this edge.
            word_d     = debug_data;
            byte_idx_d = 2'd0;
            tvalid_d   = 1'b1;
            tdata_d    = debug_data[7:0];
            tlast_d    = 1'b0;
            state_d    = S_SEND;
         end
         S_SEND: begin
            // tvalid_q is always 1 here, so tready alone marks a transfer.
            if (m.tready) begin
               if (byte_idx_q != 2'd3) begin
                  byte_idx_d = nxt_idx;
                  tdata_d    = word_q[{nxt_idx, 3'b000} +: 8];
                  tlast_d    = (remaining_q == CNT_WIDTH'(1)) && (nxt_idx == 2'd3);
               end else begin
                  remaining_d = remaining_q - CNT_WIDTH'(1);
                  addr_d      = addr_q + ADDR_WIDTH'(4);
                  tvalid_d    = 1'b0;
                  tlast_d     = 1'b0;
                  if (remaining_q > CNT_WIDTH'(1)) begin
                     state_d      = S_READ;
                     debug_addr_d = addr_q + ADDR_WIDTH'(4);
                  end else begin
                     state_d = S_FIN;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         S_FIN: begin
            done_d   = 1'b0;
            busy_d   = 1'b0;
            tvalid_d = 1'b0;
            state_d  = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         remaining_q  <= '0;
         word_q       <= '0;
         byte_idx_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         tvalid_q     <= 1'b0;
         tlast_q      <= 1'b0;
         tdata_q      <= '0;
         debug_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         remaining_q  <= remaining_d;
         word_q       <= word_d;
         byte_idx_q   <= byte_idx_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         tvalid_q     <= tvalid_d;
         tlast_q      <= tlast_d;
         tdata_q      <= tdata_d;
         debug_addr_q <= debug_addr_d;
      end
   end

endmodule

// File: tb/tb_bram_dump.sv
// tb_bram_dump: scoreboard bench for bram_dump with a registered-read BRAM model.
module tb_bram_dump;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  base;
   logic [8:0]  cnt;
   logic        busy;
   logic        done;
   logic [9:0]  debug_addr;
   logic [31:0] debug_data;
   logic [31:0] mem [256];

   bram_dump_if sif ();

   bram_dump #(
      .ADDR_WIDTH (10),
      .DATA_WIDTH (32),
      .CNT_WIDTH  (9)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .base_addr  (base),
      .word_cnt   (cnt),
      .busy       (busy),
      .done       (done),
      .debug_addr (debug_addr),
      .debug_data (debug_data),
      .m          (sif)
   );

   always #5 clk = ~clk;

   always @(posedge clk) debug_data <= mem[debug_addr[9:2]];

   int n_checks = 0;
   int n_fail = 0;
   int done_total = 0;
   int rdy_mode = 0;
   int hold_cnt = 0;
   logic [8:0] exp_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic l);
      exp_q.push_back({l, d});
   endtask

   // Downstream ready: always 1, or pseudo-random with a 5-cycle stall on the last byte.
   initial begin
      sif.tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (rdy_mode == 0) sif.tready = 1'b1;
         else if (sif.tvalid && sif.tlast && hold_cnt < 5) begin
            sif.tready = 1'b0;
            hold_cnt++;
         end else sif.tready = 1'($urandom_range(0, 1));
      end
   end

   // Monitor: pops the scoreboard on every beat and checks stall stability.
   logic       stall_prev = 1'b0;
   logic [7:0] prev_data;
   logic       prev_last;
   always @(negedge clk) begin
      if (rst) begin
         if (stall_prev) begin
            chk("hold_valid", 32'(sif.tvalid), 1);
            chk("hold_data", 32'(sif.tdata), 32'(prev_data));
            chk("hold_last", 32'(sif.tlast), 32'(prev_last));
         end
         if (sif.tvalid && sif.tready) begin
            if (exp_q.size() == 0) chk("unexpected_byte", 32'(exp_q.size()), 1);
            else begin
               logic [8:0] e;
               e = exp_q.pop_front();
               chk("byte_data", 32'(sif.tdata), 32'(e[7:0]));
               chk("byte_last", 32'(sif.tlast), 32'(e[8]));
            end
         end
         stall_prev = sif.tvalid && !sif.tready;
         prev_data  = sif.tdata;
         prev_last  = sif.tlast;
         if (done) done_total++;
      end else stall_prev = 1'b0;
   end

   task automatic run_dump(input logic [9:0] b, input logic [8:0] c, input bit repulse,
                           output int done_cyc, output int first_v, output int busy_seen,
                           output logic [9:0] da1, output logic [9:0] da7);
      done_cyc = 0; first_v = 0; busy_seen = 0; da1 = '0; da7 = '0;
      @(negedge clk);
      start = 1'b1; base = b; cnt = c;
      @(posedge clk);
      #1;
      start = 1'b0; base = 10'h155; cnt = 9'd5;
      for (int i = 1; i <= 400; i++) begin
         @(negedge clk);
         if (i == 1) da1 = debug_addr;
         if (i == 7) da7 = debug_addr;
         if (busy) busy_seen = 1;
         if (sif.tvalid && first_v == 0) first_v = i;
         if (done) begin
            done_cyc = i;
            chk("busy_at_done", 32'(busy), 0);
            if (repulse) begin start = 1'b1; base = 10'h040; cnt = 9'd7; end
            break;
         end
         if (repulse && (i == 5 || i == 10)) begin
            start = 1'b1; base = 10'h040; cnt = 9'd7;
         end else start = 1'b0;
      end
      if (done_cyc == 0) chk("done_timeout", 0, 1);
      @(negedge clk);
      start = 1'b0;
      chk("done_one_cycle", 32'(done), 0);
      chk("busy_after", 32'(busy), 0);
      chk("scoreboard_empty", 32'(exp_q.size()), 0);
   endtask

   int dc, fv, bs, d0;
   logic [9:0] a1, a7;
   int extra;

   initial begin
      foreach (mem[i]) mem[i] = '0;
      mem[0] = 32'h0000002A;
      mem[1] = 32'h00000002;
      mem[2] = 32'hFFFFFFD6;
      rst = 1'b0; start = 1'b0; base = '0; cnt = '0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_tvalid", 32'(sif.tvalid), 0);
      chk("rst_tlast", 32'(sif.tlast), 0);
      chk("rst_tdata", 32'(sif.tdata), 0);
      chk("rst_debug_addr", 32'(debug_addr), 0);
      @(negedge clk);
      rst = 1'b1;

      // Three words, ready always high.
      push(8'h2A,0); push(8'h00,0); push(8'h00,0); push(8'h00,0);
      push(8'h02,0); push(8'h00,0); push(8'h00,0); push(8'h00,0);
      push(8'hD6,0); push(8'hFF,0); push(8'hFF,0); push(8'hFF,1);
      d0 = done_total;
      run_dump(10'h000, 9'd3, 0, dc, fv, bs, a1, a7);
      chk("a_first_valid", 32'(fv), 3);
      chk("a_done_cycle", 32'(dc), 19);
      chk("a_busy", 32'(bs), 1);
      chk("a_addr0", 32'(a1), 32'h000);
      chk("a_addr1", 32'(a7), 32'h004);
      chk("a_done_count", 32'(done_total - d0), 1);

      // Same data, ready toggling.
      push(8'h2A,0); push(8'h00,0); push(8'h00,0); push(8'h00,0);
      push(8'h02,0); push(8'h00,0); push(8'h00,0); push(8'h00,0);
      push(8'hD6,0); push(8'hFF,0); push(8'hFF,0); push(8'hFF,1);
      hold_cnt = 0; rdy_mode = 1;
      d0 = done_total;
      run_dump(10'h000, 9'd3, 0, dc, fv, bs, a1, a7);
      rdy_mode = 0;
      chk("b_first_valid", 32'(fv), 3);
      chk("b_last_stall", 32'(hold_cnt), 5);
      chk("b_done_count", 32'(done_total - d0), 1);

      // Zero-length dump.
      d0 = done_total;
      run_dump(10'h010, 9'd0, 0, dc, fv, bs, a1, a7);
      chk("z_done_cycle", 32'(dc), 1);
      chk("z_no_valid", 32'(fv), 0);
      chk("z_no_busy", 32'(bs), 0);
      chk("z_done_count", 32'(done_total - d0), 1);

      // Address wrap from the top word to word 0.
      mem[255] = 32'hA8A8A8A8;
      mem[0]   = 32'h000000F5;
      push(8'hA8,0); push(8'hA8,0); push(8'hA8,0); push(8'hA8,0);
      push(8'hF5,0); push(8'h00,0); push(8'h00,0); push(8'h00,1);
      run_dump(10'h3FD, 9'd2, 0, dc, fv, bs, a1, a7);
      chk("w_addr0", 32'(a1), 32'h3FC);
      chk("w_addr1", 32'(a7), 32'h000);
      chk("w_done_cycle", 32'(dc), 13);

      // Start re-pulsed while busy and in FIN is ignored.
      push(8'h02,0); push(8'h00,0); push(8'h00,0); push(8'h00,0);
      push(8'hD6,0); push(8'hFF,0); push(8'hFF,0); push(8'hFF,1);
      d0 = done_total;
      run_dump(10'h004, 9'd2, 1, dc, fv, bs, a1, a7);
      chk("r_done_cycle", 32'(dc), 13);
      extra = 0;
      repeat (10) begin
         @(negedge clk);
         if (busy || sif.tvalid || done) extra++;
      end
      chk("r_no_second_dump", 32'(extra), 0);
      chk("r_done_count", 32'(done_total - d0), 1);
      push(8'hA8,0); push(8'hA8,0); push(8'hA8,0); push(8'hA8,1);
      run_dump(10'h3FC, 9'd1, 0, dc, fv, bs, a1, a7);
      chk("r_idle_dump_done", 32'(dc), 7);

      // Reset during byte 2 of word 1; the byte presented then is seen by the monitor.
      push(8'h02,0); push(8'h00,0); push(8'h00,0); push(8'h00,0);
      push(8'hD6,0); push(8'hFF,0); push(8'hFF,0);
      d0 = done_total;
      @(negedge clk);
      start = 1'b1; base = 10'h004; cnt = 9'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      for (int i = 1; i <= 11; i++) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk("x_tvalid", 32'(sif.tvalid), 0);
      chk("x_busy", 32'(busy), 0);
      chk("x_done", 32'(done), 0);
      chk("x_tlast", 32'(sif.tlast), 0);
      repeat (2) @(negedge clk);
      chk("x_done_held", 32'(done), 0);
      rst = 1'b1;
      chk("x_done_count", 32'(done_total - d0), 0);
      chk("x_scoreboard", 32'(exp_q.size()), 0);
      push(8'hD6,0); push(8'hFF,0); push(8'hFF,0); push(8'hFF,1);
      run_dump(10'h008, 9'd1, 0, dc, fv, bs, a1, a7);
      chk("x_new_dump_done", 32'(dc), 7);
      chk("x_new_addr", 32'(a1), 32'h008);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
